idu_stage: RTL and testbench

//  Pipelined, parametrised RV32I decode stage: buffers fetched instructions in an IQ_DEPTH-entry queue,

---
 rtl/idu_pkg.sv | 72 +++++++
 rtl/idu_decode.sv | 117 +++++++++++
 rtl/idu_stage.sv | 93 +++++++++
 tb/tb_idu_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// idu_pkg: shared opcodes, one-hot indices, select codes and the decoded bundle for the decode stage.
// IDU_RV32M_EN widens the ALU op vector to carry the multiply/divide group.
package idu_pkg;
`ifdef IDU_RV32M_EN
   localparam int ALU_OP_W = 18;
`else
   localparam int ALU_OP_W = 10;
`endif
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam int ALU_ADD = 0;
   localparam int ALU_SUB = 1;
   localparam int ALU_SLT = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND = 4;
   localparam int ALU_OR = 5;
   localparam int ALU_XOR = 6;
   localparam int ALU_SLL = 7;
   localparam int ALU_SRL = 8;
   localparam int ALU_SRA = 9;
   localparam int ALU_MUL = 10;
   localparam int J_JAL = 0;
   localparam int J_JALR = 1;
   localparam int J_BEQ = 2;
   localparam int M_SB = 0;
   localparam int M_LB = 3;
   localparam logic [2:0] S1_RS1 = 3'b001;
   localparam logic [2:0] S1_PC = 3'b010;
   localparam logic [2:0] S1_ZERO = 3'b100;
   localparam logic [2:0] S2_RS2 = 3'b001;
   localparam logic [2:0] S2_IMM = 3'b010;
   localparam logic [2:0] S2_FOUR = 3'b100;
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [31:0] imm;
      logic [ALU_OP_W-1:0] alu_op;
      logic [7:0] jump_type;
      logic [7:0] mem_type;
      logic [2:0] src1_sel;
      logic [2:0] src2_sel;
      logic rf_wen;
      logic wb_sel;
      logic dram_en;
      logic dram_wen;
      logic illegal;
      logic ebreak;
      logic fence;
   } bundle_t;
   // alt selects sub/sra for funct3 000/101 respectively
   function automatic logic [ALU_OP_W-1:0] alu_oh(input logic [2:0] f3, input logic alt);
      int i;
      i = f3 == 3'b000 ? (alt ? ALU_SUB : ALU_ADD) :
          f3 == 3'b001 ? ALU_SLL :
          f3 == 3'b010 ? ALU_SLT :
          f3 == 3'b011 ? ALU_SLTU :
          f3 == 3'b100 ? ALU_XOR :
          f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
          f3 == 3'b110 ? ALU_OR : ALU_AND;
      return ALU_OP_W'(1) << i;
   endfunction
endpackage

// File: rtl/idu_decode.sv
// idu_decode: combinational RV32I(+M with IDU_RV32M_EN) instruction word to decoded bundle.
module idu_decode
   import idu_pkg::*;
(
   input  logic [31:0] inst,
   output bundle_t     dec
);
   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic ill;
   bundle_t d;
   assign opc = inst[6:0];
   assign f3 = inst[14:12];
   assign f7 = inst[31:25];
   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   always_comb begin
      d = '0;
      ill = 1'b0;
      case (opc)
         OP_LUI: begin
            d.imm = imm_u;
            d.alu_op[ALU_ADD] = 1'b1;
            d.src1_sel = S1_ZERO;
            d.src2_sel = S2_IMM;
            d.rf_wen = 1'b1;
         end
         OP_AUIPC: begin
            d.imm = imm_u;
            d.alu_op[ALU_ADD] = 1'b1;
            d.src1_sel = S1_PC;
            d.src2_sel = S2_IMM;
            d.rf_wen = 1'b1;
         end
         OP_JAL, OP_JALR: begin
            ill = opc == OP_JALR && f3 != 3'b000;
            d.imm = opc == OP_JAL ? imm_j : imm_i;
            d.jump_type[opc == OP_JAL ? J_JAL : J_JALR] = 1'b1;
            d.alu_op[ALU_ADD] = 1'b1;
            d.src1_sel = S1_PC;
            d.src2_sel = S2_FOUR;
            d.rf_wen = 1'b1;
         end
         OP_BRANCH: begin
            // funct3 {000,001,100..111} -> bits 2..7, 010/011 reserved
            ill = f3[2:1] == 2'b01;
            d.imm = imm_b;
            d.jump_type = 8'(1) << (f3[2] ? int'(f3) : J_BEQ + int'(f3));
            d.alu_op[ALU_ADD] = 1'b1;
            d.src1_sel = S1_PC;
            d.src2_sel = S2_IMM;
         end
         OP_LOAD: begin
            ill = f3 == 3'b011 || f3[2:1] == 2'b11;
            d.imm = imm_i;
            d.mem_type = 8'(1) << (f3[2] ? M_LB - 1 + int'(f3) : M_LB + int'(f3));
            d.alu_op[ALU_ADD] = 1'b1;
            d.src1_sel = S1_RS1;
            d.src2_sel = S2_IMM;
            d.rf_wen = 1'b1;
            d.wb_sel = 1'b1;
            d.dram_en = 1'b1;
         end
         OP_STORE: begin
            ill = f3 > 3'b010;
            d.imm = imm_s;
            d.mem_type = 8'(1) << (M_SB + int'(f3));
            d.alu_op[ALU_ADD] = 1'b1;
            d.src1_sel = S1_RS1;
            d.src2_sel = S2_IMM;
            d.dram_en = 1'b1;
            d.dram_wen = 1'b1;
         end
         OP_IMM: begin
            ill = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
            d.imm = imm_i;
            d.alu_op = alu_oh(f3, f3 == 3'b101 && f7[5]);
            d.src1_sel = S1_RS1;
            d.src2_sel = S2_IMM;
            d.rf_wen = 1'b1;
         end
         OP_OP: begin
            d.src1_sel = S1_RS1;
            d.src2_sel = S2_RS2;
            d.rf_wen = 1'b1;
            if (f7 == 7'h01) begin
`ifdef IDU_RV32M_EN
               d.alu_op = ALU_OP_W'(1) << (ALU_MUL + int'(f3));
`else
               ill = 1'b1;
`endif
            end else begin
               ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
               d.alu_op = alu_oh(f3, f7[5]);
            end
         end
         OP_FENCE: d.fence = 1'b1;
         OP_SYSTEM: begin
            ill = inst != 32'h0000_0073 && inst != 32'h0010_0073;
            d.ebreak = inst == 32'h0010_0073;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         d = '0;
         d.illegal = 1'b1;
      end
      d.rs1 = inst[19:15];
      d.rs2 = inst[24:20];
      d.rd = d.rf_wen ? inst[11:7] : 5'd0;
   end
   assign dec = d;
endmodule

// File: rtl/idu_stage.sv
// idu_stage: buffered RV32I decode stage (IQ_DEPTH-entry queue, decoder, registered bundle).
// Define IDU_RV32M_EN to accept the M extension.
module idu_stage
   import idu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int IQ_DEPTH = 4
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     in_pc,
   input  logic [31:0]         in_inst,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [4:0]          out_rd,
   output logic [XLEN-1:0]     out_imm,
   output logic [ALU_OP_W-1:0] out_alu_op,
   output logic [7:0]          out_jump_type,
   output logic [7:0]          out_mem_type,
   output logic [2:0]          out_src1_sel,
   output logic [2:0]          out_src2_sel,
   output logic                out_rf_wen,
   output logic                out_wb_sel,
   output logic                out_dram_en,
   output logic                out_dram_wen,
   output logic                out_illegal,
   output logic                out_ebreak,
   output logic                out_fence
);
   localparam int PW = $clog2(IQ_DEPTH);
   localparam int CW = PW + 1;
   logic [XLEN-1:0] pc_q [IQ_DEPTH];
   logic [31:0] inst_q [IQ_DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic push, pop;
   bundle_t dec, ob;
   assign in_ready = count != CW'(IQ_DEPTH);
   assign push = in_valid & in_ready;
   assign pop = count != '0 && (!out_valid || out_ready);
   idu_decode u_decode (.inst(inst_q[rptr]), .dec(dec));
   always_ff @(posedge clk)
      if (push) begin
         pc_q[wptr] <= in_pc;
         inst_q[wptr] <= in_inst;
      end
   // flush only rewinds state; storage written under flush is never read
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         out_valid <= 1'b0;
         out_pc <= '0;
         ob <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) begin
            rptr <= rptr + 1'b1;
            out_pc <= pc_q[rptr];
            ob <= dec;
         end
         count <= count + CW'(push) - CW'(pop);
         out_valid <= pop || (out_valid && !out_ready);
      end
   assign out_rs1 = ob.rs1;
   assign out_rs2 = ob.rs2;
   assign out_rd = ob.rd;
   assign out_imm = ob.imm;
   assign out_alu_op = ob.alu_op;
   assign out_jump_type = ob.jump_type;
   assign out_mem_type = ob.mem_type;
   assign out_src1_sel = ob.src1_sel;
   assign out_src2_sel = ob.src2_sel;
   assign out_rf_wen = ob.rf_wen;
   assign out_wb_sel = ob.wb_sel;
   assign out_dram_en = ob.dram_en;
   assign out_dram_wen = ob.dram_wen;
   assign out_illegal = ob.illegal;
   assign out_ebreak = ob.ebreak;
   assign out_fence = ob.fence;
endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: table-driven scoreboard bench for idu_stage (honours IDU_RV32M_EN).
module tb_idu_stage;
   import idu_pkg::*;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [4:0] rd;
      logic [17:0] alu;
      logic [7:0] jt;
      logic [7:0] mt;
      logic [2:0] s1;
      logic [2:0] s2;
      logic [6:0] fl;
   } vec_t;
   typedef struct packed {
      logic [31:0] pc;
      vec_t v;
   } exp_t;
   localparam logic [6:0] RW = 7'b1000000, WB = 7'b0100000, DE = 7'b0010000, DW = 7'b0001000;
   localparam logic [6:0] IL = 7'b0000100, EB = 7'b0000010, FE = 7'b0000001;
   logic clk = 1'b0, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, in_inst, out_pc, out_imm;
   logic [4:0] out_rs1, out_rs2, out_rd;
   logic [ALU_OP_W-1:0] out_alu_op;
   logic [7:0] out_jump_type, out_mem_type;
   logic [2:0] out_src1_sel, out_src2_sel;
   logic out_rf_wen, out_wb_sel, out_dram_en, out_dram_wen, out_illegal, out_ebreak, out_fence;
   int errors = 0, checks = 0, w, stalls;
   bit rnd = 1'b0;
   logic [31:0] pc_n;
   vec_t tbl[$];
   exp_t exp_q[$];
   exp_t me;

   idu_stage #(.XLEN(32), .IQ_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
      .out_alu_op(out_alu_op), .out_jump_type(out_jump_type), .out_mem_type(out_mem_type),
      .out_src1_sel(out_src1_sel), .out_src2_sel(out_src2_sel), .out_rf_wen(out_rf_wen),
      .out_wb_sel(out_wb_sel), .out_dram_en(out_dram_en), .out_dram_wen(out_dram_wen),
      .out_illegal(out_illegal), .out_ebreak(out_ebreak), .out_fence(out_fence));

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] imm, input logic [4:0] rd,
                               input logic [17:0] alu, input logic [7:0] jt, input logic [7:0] mt,
                               input logic [2:0] s1, input logic [2:0] s2, input logic [6:0] fl);
      return '{inst, imm, rd, alu, jt, mt, s1, s2, fl};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] flags();
      return {out_rf_wen, out_wb_sel, out_dram_en, out_dram_wen, out_illegal, out_ebreak, out_fence};
   endfunction

   // the transfer seen here completes at the following rising edge
   always @(negedge clk)
      if (rst_n && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got pc %h, expected no output", out_pc);
         end else begin
            me = exp_q.pop_front();
            chk($sformatf("%h.pc", me.v.inst), out_pc, me.pc);
            chk($sformatf("%h.rs", me.v.inst), 32'({out_rs1, out_rs2}), 32'({me.v.inst[19:15], me.v.inst[24:20]}));
            chk($sformatf("%h.rd", me.v.inst), 32'(out_rd), 32'(me.v.rd));
            chk($sformatf("%h.imm", me.v.inst), out_imm, me.v.imm);
            chk($sformatf("%h.alu_op", me.v.inst), 32'(out_alu_op), 32'(me.v.alu));
            chk($sformatf("%h.jump_mem", me.v.inst), 32'({out_jump_type, out_mem_type}), 32'({me.v.jt, me.v.mt}));
            chk($sformatf("%h.src_sel", me.v.inst), 32'({out_src1_sel, out_src2_sel}), 32'({me.v.s1, me.v.s2}));
            chk($sformatf("%h.flags", me.v.inst), 32'(flags()), 32'(me.v.fl));
         end
      end

   task automatic push_inst(input vec_t v, output int waited);
      int n = 0;
      in_valid = 1'b1;
      in_pc = pc_n;
      in_inst = v.inst;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      waited = n;
      if (!in_ready) begin
         chk("push_timeout", 32'(in_ready), 32'd1);
      end else begin
         exp_q.push_back('{pc_n, v});
         @(posedge clk);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      pc_n = pc_n + 32'd4;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic rst_checks(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_pc_imm"}, out_pc | out_imm, 32'd0);
      chk({tag, "_alu_jump_mem"}, 32'(out_alu_op) | 32'({out_jump_type, out_mem_type}), 32'd0);
      chk({tag, "_fields"}, 32'({out_src1_sel, out_src2_sel, out_rs1, out_rs2, out_rd, flags()}), 32'd0);
   endtask

   initial begin
      tbl.push_back(mk(32'h00500093, 32'd5, 5'd1, 18'h1, 8'h00, 8'h00, 3'b001, 3'b010, RW));
      tbl.push_back(mk(32'hfe000ee3, 32'hfffffffc, 5'd0, 18'h1, 8'h04, 8'h00, 3'b010, 3'b010, 7'd0));
      tbl.push_back(mk(32'h0020a423, 32'd8, 5'd0, 18'h1, 8'h00, 8'h04, 3'b001, 3'b010, DE | DW));
      tbl.push_back(mk(32'h123452b7, 32'h12345000, 5'd5, 18'h1, 8'h00, 8'h00, 3'b100, 3'b010, RW));
      tbl.push_back(mk(32'h00001197, 32'h00001000, 5'd3, 18'h1, 8'h00, 8'h00, 3'b010, 3'b010, RW));
      tbl.push_back(mk(32'h008000ef, 32'd8, 5'd1, 18'h1, 8'h01, 8'h00, 3'b010, 3'b100, RW));
      tbl.push_back(mk(32'h00008067, 32'd0, 5'd0, 18'h1, 8'h02, 8'h00, 3'b010, 3'b100, RW));
      tbl.push_back(mk(32'hffc12303, 32'hfffffffc, 5'd6, 18'h1, 8'h00, 8'h20, 3'b001, 3'b010, RW | WB | DE));
      tbl.push_back(mk(32'h00104383, 32'd1, 5'd7, 18'h1, 8'h00, 8'h40, 3'b001, 3'b010, RW | WB | DE));
      tbl.push_back(mk(32'h402081b3, 32'd0, 5'd3, 18'h2, 8'h00, 8'h00, 3'b001, 3'b001, RW));
      tbl.push_back(mk(32'h4062d233, 32'd0, 5'd4, 18'h200, 8'h00, 8'h00, 3'b001, 3'b001, RW));
      tbl.push_back(mk(32'h4030d093, 32'h403, 5'd1, 18'h200, 8'h00, 8'h00, 3'b001, 3'b010, RW));
      tbl.push_back(mk(32'hfff0b113, 32'hffffffff, 5'd2, 18'h8, 8'h00, 8'h00, 3'b001, 3'b010, RW));
      tbl.push_back(mk(32'h00100073, 32'd0, 5'd0, 18'h0, 8'h00, 8'h00, 3'b000, 3'b000, EB));
      tbl.push_back(mk(32'h00000073, 32'd0, 5'd0, 18'h0, 8'h00, 8'h00, 3'b000, 3'b000, 7'd0));
      tbl.push_back(mk(32'h0ff0000f, 32'd0, 5'd0, 18'h0, 8'h00, 8'h00, 3'b000, 3'b000, FE));
      tbl.push_back(mk(32'hffffffff, 32'd0, 5'd0, 18'h0, 8'h00, 8'h00, 3'b000, 3'b000, IL));
`ifdef IDU_RV32M_EN
      tbl.push_back(mk(32'h02208033, 32'd0, 5'd0, 18'h400, 8'h00, 8'h00, 3'b001, 3'b001, RW));
`else
      tbl.push_back(mk(32'h02208033, 32'd0, 5'd0, 18'h0, 8'h00, 8'h00, 3'b000, 3'b000, IL));
`endif
      tbl.push_back(mk(32'h40009093, 32'd0, 5'd0, 18'h0, 8'h00, 8'h00, 3'b000, 3'b000, IL));
      tbl.push_back(mk(32'h0000b083, 32'd0, 5'd0, 18'h0, 8'h00, 8'h00, 3'b000, 3'b000, IL));
      tbl.push_back(mk(32'h30001073, 32'd0, 5'd0, 18'h0, 8'h00, 8'h00, 3'b000, 3'b000, IL));
      tbl.push_back(mk(32'h007362b3, 32'd0, 5'd5, 18'h20, 8'h00, 8'h00, 3'b001, 3'b001, RW));
      tbl.push_back(mk(32'h0020f463, 32'd8, 5'd0, 18'h1, 8'h80, 8'h00, 3'b010, 3'b010, 7'd0));
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in_pc = '0;
      in_inst = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_checks("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_release_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_pc = 32'h8000_0000;
      in_inst = tbl[0].inst;
      exp_q.push_back('{32'h8000_0000, tbl[0]});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("lat_t1_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_t2_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      chk("lat_t3_valid", 32'(out_valid), 32'd0);
      pc_n = 32'h8000_0004;
      stalls = 0;
      foreach (tbl[i]) begin
         push_inst(tbl[i], w);
         stalls += w;
      end
      chk("stream_stalls", 32'(stalls), 32'd0);
      drain();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_inst(tbl[3 + i], w);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("bp_hold_pc", out_pc, exp_q[0].pc);
         chk("bp_hold_full", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      push_inst(tbl[8], w);
      chk("bp_release_wait", 32'(w), 32'd1);
      drain();
      out_ready = 1'b0;
      push_inst(tbl[9], w);
      push_inst(tbl[10], w);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_pc = pc_n;
      in_inst = tbl[11].inst;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("flush_empty", 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_inst(tbl[12 + i], w);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      rst_checks("mid_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_after_valid", 32'(out_valid), 32'd0);
      rnd = 1'b1;
      foreach (tbl[i]) push_inst(tbl[i], w);
      drain();
      rnd = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end
endmodule
